// File: rtl/writeback_unit_pkg.sv
// Shared writeback types: result-source select, ALU op codes, decode bundle,
// load funct3 encodings and the queued writeback entry.
package writeback_unit_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       regw;
      alu_op_t    alu_op;
      wb_sel_t    wb_sel;
   } bundle_decode_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] value;
   } wb_entry_t;

endpackage

// File: rtl/writeback_unit_load_extender.sv
// Combinational load alignment and sign/zero extension of a raw memory word.
// Unknown funct3 values fall through to a full-word load.
module load_extender
   import writeback_unit_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   output logic [31:0] value_o
);

   logic [7:0]  lane_bytes [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_bytes[gi] = data_i[8*gi +: 8];
      end
   endgenerate

   assign byte_sel = lane_bytes[off_i];
   // Halfword loads are assumed aligned, so only off_i[1] picks the half.
   assign half_sel = off_i[1] ? data_i[31:16] : data_i[15:0];

   always_comb begin
      value_o = data_i;
      case (funct3_i)
         F3_LB:   value_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  value_o = {24'h000000, byte_sel};
         F3_LH:   value_o = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  value_o = {16'h0000, half_sel};
         F3_LW:   value_o = data_i;
         default: value_o = data_i;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: result FIFO feeding the register-file write port, plus a
// pending-write scoreboard that stalls issue on RAW/WAW hazards.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [4:0]  issue_rs1,
   input  logic [4:0]  issue_rs2,
   input  logic [4:0]  issue_rd,
   input  logic        issue_regw,
   input  logic        res_valid,
   output logic        res_ready,
   input  logic [4:0]  res_rd,
   input  logic [31:0] res_data,
   input  logic [31:0] res_pc4,
   input  wb_sel_t     res_sel,
   input  logic [2:0]  res_funct3,
   input  logic [1:0]  res_off,
   input  logic        wb_en,
   output logic        rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_wd,
   output logic [31:0] busy
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   wb_entry_t    fifo_q [DEPTH];
   logic [31:0]  busy_q, busy_d;

   logic         empty, full, enq, deq, issue_fire;
   logic [31:0]  load_value;
   wb_entry_t    enq_entry;
   wb_entry_t    head;

   load_extender u_load_extender (
      .data_i   (res_data),
      .funct3_i (res_funct3),
      .off_i    (res_off),
      .value_o  (load_value)
   );

   always_comb begin
      enq_entry.rd    = res_rd;
      enq_entry.value = res_data;
      case (res_sel)
         WB_ALU:  enq_entry.value = res_data;
         WB_MEM:  enq_entry.value = load_value;
         WB_PC4:  enq_entry.value = res_pc4;
         default: enq_entry.value = res_data;
      endcase
   end

   // Extra pointer MSB tells a full queue apart from an empty one.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign res_ready = !full;
   assign enq       = res_valid && !full;
   assign deq       = !empty && wb_en;
   assign head      = fifo_q[rd_ptr_q[AW-1:0]];

   // x0 results still drain through the queue but never assert the write strobe.
   assign rf_we   = deq && (head.rd != 5'd0);
   assign rf_addr = empty ? 5'd0  : head.rd;
   assign rf_wd   = empty ? 32'd0 : head.value;

   assign wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage carries no reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_q[wr_ptr_q[AW-1:0]] <= enq_entry;
      end
   end

   assign issue_ready = !busy_q[issue_rs1] && !busy_q[issue_rs2] &&
                        !(issue_regw && busy_q[issue_rd]);
   assign issue_fire  = issue_valid && issue_ready;

   // Set is applied after clear so a same-cycle reissue keeps the bit pending.
   always_comb begin
      busy_d = busy_q;
      if (deq) begin
         busy_d[head.rd] = 1'b0;
      end
      if (issue_fire && issue_regw) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning result FIFO entries (power of two, >=2).
REQ-002 SHALL have clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have reset  in  1  asynchronous, active-high reset; one clock domain only.
REQ-004 SHALL have issue_valid/issue_ready  in/out  1/1  issue handshake from decode.
REQ-005 SHALL have issue_rs1, issue_rs2, issue_rd  in  5 each  source and destination register indices.
REQ-006 SHALL have issue_regw  in  1  issued instruction writes issue_rd.
REQ-007 SHALL have res_valid/res_ready  in/out  1/1  result handshake from execute/memory.
REQ-008 SHALL have res_rd  in  5; res_data  in  32  ALU result or raw memory word; res_pc4  in  32  PC+4.
REQ-009 SHALL have res_sel  in  wb_sel_t  WB_ALU, WB_MEM or WB_PC4; res_funct3  in  3; res_off  in  2  byte offset.
REQ-010 SHALL have wb_en  in  1  register-file write port granted this cycle.
REQ-011 SHALL have rf_we, rf_addr, rf_wd  out  1/5/32  driven to register-file WE3/A3/WD3.
REQ-012 SHALL have busy  out  32  pending-write scoreboard; busy[0] constant 0.

Function
REQ-013 SHALL compute the write value at enqueue: WB_ALU -> res_data; WB_PC4 -> res_pc4; WB_MEM -> load-extended res_data.
REQ-014 Load extension SHALL be: 000 LB sign-ext byte res_off; 100 LBU zero-ext; 001 LH sign-ext half res_off[1]; 101 LHU zero-ext; 010 and others -> full word.
REQ-015 SHALL hold computed {rd, value} in a DEPTH-entry FIFO; res_ready = !full; enqueue on res_valid && res_ready.
REQ-016 SHALL assert rf_we = !empty && wb_en combinationally, rf_addr/rf_wd = FIFO head; dequeue on rf_we.
REQ-017 Minimum latency result accept -> rf_we SHALL be 1 cycle (registered FIFO, no bypass).
REQ-018 Simultaneous enqueue and dequeue SHALL be legal when full (res_ready stays 0 that cycle; no combinational ready from wb_en) and when empty+wb_en (entry stored, written next cycle).
REQ-019 Pointers SHALL wrap modulo DEPTH with one extra bit distinguishing full from empty.
REQ-020 issue_ready SHALL be !busy[issue_rs1] && !busy[issue_rs2] && !(issue_regw && busy[issue_rd]).
REQ-021 On issue_valid && issue_ready && issue_regw && issue_rd!=0, busy[issue_rd] SHALL set next cycle.
REQ-022 On dequeue, busy[rf_addr] SHALL clear next cycle; same-index set and clear in one cycle -> set wins.
REQ-023 Results with res_rd=0 SHALL be enqueued and dequeued but SHALL produce rf_we=0.
REQ-024 A result for a register whose busy bit is clear SHALL still be written (scoreboard is advisory).

Reset
REQ-025 On reset: FIFO empty, busy=0, rf_we=0, rf_addr=0, rf_wd=0, res_ready=1, issue_ready=1.
REQ-026 Reset mid-operation SHALL discard all queued results immediately; no write reaches the register file after reset asserts.
REQ-027 Reset SHALL take effect asynchronously and release synchronously to clk.

Structure
REQ-028 wb_sel_t (WB_ALU, WB_MEM, WB_PC4) SHALL live in Pkg beside alu_op_t and bundle_decode_t; funct3 load encodings SHALL be Pkg localparams.
REQ-029 Load extension SHALL be a combinational sub-module load_extender instantiated once.
REQ-030 FIFO and scoreboard SHALL be in writeback_unit itself; no latches.

Verification
REQ-031 WB_MEM, funct3=000, off=2, data=0x0080_FF00, wb_en=1 -> next cycle rf_we=1, rf_wd=0xFFFF_FF80.
REQ-032 WB_MEM, funct3=101, off=2, data=0x8001_1234 -> rf_wd=0x0000_8001; funct3=001 same data -> 0xFFFF_8001.
REQ-033 wb_en=0, DEPTH=2, three back-to-back results -> res_ready falls after two; raise wb_en -> writes in order, rd=5,6,7.
REQ-034 Issue rd=9 regw=1 -> busy[9]=1; issue rs1=9 -> issue_ready=0; result rd=9 dequeued -> busy[9]=0 next cycle, issue_ready=1.
REQ-035 Dequeue rd=9 and issue rd=9 same cycle -> busy[9] remains 1.
REQ-036 Two results queued, reset pulsed mid-cycle -> rf_we=0 immediately, busy=0, empty after release.
